// File: rtl/truth_table_sweeper.sv
// Walks all 32 minterms through an external 5-input function, rebuilds its truth table
// and compares it against an expected table, reporting the lowest differing minterm.
module truth_table_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] expected,
  input  logic        fn_out,
  output logic [4:0]  stim,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_out,
  output logic [5:0]  ones_count,
  output logic        match,
  output logic        mismatch_valid,
  output logic [4:0]  first_mismatch
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  logic [1:0]  state;
  logic [4:0]  index;
  logic [3:0]  settle_cnt;
  logic [31:0] exp_q;
  logic        bit_diff;
  logic        mv_next;

  assign bit_diff = fn_out ^ exp_q[index];
  // match must include a mismatch found on the very last minterm
  assign mv_next  = mismatch_valid | bit_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      index          <= '0;
      settle_cnt     <= '0;
      exp_q          <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      table_out      <= '0;
      ones_count     <= '0;
      match          <= 1'b0;
      mismatch_valid <= 1'b0;
      first_mismatch <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state          <= DRIVE;
            index          <= '0;
            stim           <= '0;
            exp_q          <= expected;
            table_out      <= '0;
            ones_count     <= '0;
            match          <= 1'b0;
            mismatch_valid <= 1'b0;
            first_mismatch <= '0;
            busy           <= 1'b1;
            settle_cnt     <= SETTLE_V;
          end
        end
        DRIVE, SAMPLE: begin
          if (abort) begin
            // partial results stay visible; only the control state unwinds
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            match      <= 1'b0;
            stim       <= '0;
            index      <= '0;
            settle_cnt <= '0;
          end else if (state == DRIVE) begin
            if (settle_cnt == 4'd0) state <= SAMPLE;
            else                    settle_cnt <= settle_cnt - 4'd1;
          end else begin
            table_out[index] <= fn_out;
            ones_count       <= ones_count + {5'd0, fn_out};
            if (bit_diff && !mismatch_valid) begin
              first_mismatch <= index;
              mismatch_valid <= 1'b1;
            end
            if (index == 5'd31) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              match <= ~mv_next;
            end else begin
              index      <= index + 5'd1;
              stim       <= index + 5'd1;
              settle_cnt <= SETTLE_V;
              state      <= DRIVE;
            end
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with SETTLE=1, one with SETTLE=0,
// sweep results queued at start and compared when done pulses.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, start0, abort1;
  logic [31:0] expected;
  logic [1:0]  fsel1, fsel0;
  logic        fn1, fn0;

  logic [4:0]  stim1, stim0, fm1, fm0;
  logic        busy1, busy0, done1, done0, match1, match0, mv1, mv0;
  logic [31:0] tbl1, tbl0;
  logic [5:0]  ones1, ones0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] tbl;
    logic [5:0]  ones;
    logic        m;
    logic        mv;
    logic [4:0]  fm;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  function automatic logic fn_eval(input logic [1:0] sel, input logic [4:0] s);
    case (sel)
      2'd0:    return 1'b1;
      2'd1:    return &s;
      2'd2:    return ~s[4] & ~s[3];
      default: return s[0];
    endcase
  endfunction

  always_comb fn1 = fn_eval(fsel1, stim1);
  always_comb fn0 = fn_eval(fsel0, stim0);

  truth_table_sweeper #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(expected),
    .fn_out(fn1), .stim(stim1), .busy(busy1), .done(done1), .table_out(tbl1),
    .ones_count(ones1), .match(match1), .mismatch_valid(mv1), .first_mismatch(fm1)
  );

  truth_table_sweeper #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0), .expected(expected),
    .fn_out(fn0), .stim(stim0), .busy(busy0), .done(done0), .table_out(tbl0),
    .ones_count(ones0), .match(match0), .mismatch_valid(mv0), .first_mismatch(fm0)
  );

  task automatic start_sweep(input bit use0, input logic [31:0] ex, input logic [1:0] f);
    @(negedge clk);
    expected = ex;
    if (use0) begin fsel0 = f; start0 = 1'b1; end
    else      begin fsel1 = f; start1 = 1'b1; end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Called right after start_sweep: the first negedge follows accept edge 0.
  task automatic wait_done(input bit use0, input bit chk_stim, input string name);
    exp_t e;
    bit   seen = 1'b0;
    int   stim_err = 0;
    int   per = use0 ? 2 : 3;
    e = sbq.pop_front();
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (chk_stim && n < e.lat && int'(use0 ? stim0 : stim1) != n / per) stim_err++;
      if (use0 ? done0 : done1) begin
        seen = 1'b1;
        checks++;
        if (n !== e.lat) begin
          errors++; $display("FAIL %s latency got %0d want %0d", name, n, e.lat);
        end
        checks++;
        if ((use0 ? tbl0 : tbl1) !== e.tbl) begin
          errors++; $display("FAIL %s table_out got %h want %h", name, use0 ? tbl0 : tbl1, e.tbl);
        end
        checks++;
        if ((use0 ? ones0 : ones1) !== e.ones) begin
          errors++; $display("FAIL %s ones_count got %0d want %0d", name, use0 ? ones0 : ones1, e.ones);
        end
        checks++;
        if ((use0 ? match0 : match1) !== e.m) begin
          errors++; $display("FAIL %s match got %b want %b", name, use0 ? match0 : match1, e.m);
        end
        checks++;
        if ((use0 ? mv0 : mv1) !== e.mv) begin
          errors++; $display("FAIL %s mismatch_valid got %b want %b", name, use0 ? mv0 : mv1, e.mv);
        end
        if (e.mv) begin
          checks++;
          if ((use0 ? fm0 : fm1) !== e.fm) begin
            errors++; $display("FAIL %s first_mismatch got %0d want %0d", name, use0 ? fm0 : fm1, e.fm);
          end
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s done timeout got none want pulse", name);
    end
    if (chk_stim) begin
      checks++;
      if (stim_err != 0) begin
        errors++; $display("FAIL %s stim sequence got %0d bad cycles want 0", name, stim_err);
      end
    end
    @(negedge clk);
    checks++;
    if ({use0 ? done0 : done1, use0 ? busy0 : busy1} !== 2'b00 || (use0 ? match0 : match1) !== e.m) begin
      errors++; $display("FAIL %s post-done done/busy/match got %b%b%b want 00%b", name,
                         use0 ? done0 : done1, use0 ? busy0 : busy1, use0 ? match0 : match1, e.m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start1 = 0; start0 = 0; abort1 = 0; expected = '0; fsel1 = 0; fsel0 = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({stim1, busy1, done1, tbl1, ones1, match1, mv1, fm1} !== '0) begin
      errors++; $display("FAIL reset dut1 got %h want 0", {stim1, busy1, done1, tbl1, ones1, match1, mv1, fm1});
    end
    checks++;
    if ({stim0, busy0, done0, tbl0, ones0, match0, mv0, fm0} !== '0) begin
      errors++; $display("FAIL reset dut0 got %h want 0", {stim0, busy0, done0, tbl0, ones0, match0, mv0, fm0});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_ones();
    sbq.push_back('{tbl: 32'hFFFF_FFFF, ones: 6'd32, m: 1'b1, mv: 1'b0, fm: 5'd0, lat: 96});
    start_sweep(1'b0, 32'hFFFF_FFFF, 2'd0);
    wait_done(1'b0, 1'b1, "all_ones");
  endtask

  task automatic test_and5();
    sbq.push_back('{tbl: 32'h8000_0000, ones: 6'd1, m: 1'b1, mv: 1'b0, fm: 5'd0, lat: 64});
    start_sweep(1'b1, 32'h8000_0000, 2'd1);
    wait_done(1'b1, 1'b1, "and5");
  endtask

  task automatic test_nor_ab();
    sbq.push_back('{tbl: 32'h0000_00FF, ones: 6'd8, m: 1'b0, mv: 1'b1, fm: 5'd5, lat: 96});
    start_sweep(1'b0, 32'h0000_00DF, 2'd2);
    wait_done(1'b0, 1'b0, "nor_ab");
  endtask

  task automatic test_abort();
    bit hit = 1'b0;
    int done_seen = 0;
    start_sweep(1'b0, 32'hFFFF_FFFF, 2'd0);
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (stim1 == 5'd10) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL abort reach stim10 got timeout want stim=10");
    end
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    checks++;
    if ({busy1, done1, match1, stim1} !== 8'd0) begin
      errors++; $display("FAIL abort ctrl busy/done/match/stim got %b%b%b %0d want 000 0", busy1, done1, match1, stim1);
    end
    checks++;
    if (tbl1 !== 32'h0000_03FF || ones1 !== 6'd10) begin
      errors++; $display("FAIL abort partial got %h/%0d want 000003ff/10", tbl1, ones1);
    end
    repeat (10) begin
      @(negedge clk);
      if (done1) done_seen++;
    end
    checks++;
    if (done_seen != 0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL abort idle done pulses got %0d busy %b want 0 0", done_seen, busy1);
    end
    sbq.push_back('{tbl: 32'hFFFF_FFFF, ones: 6'd32, m: 1'b1, mv: 1'b0, fm: 5'd0, lat: 96});
    start_sweep(1'b0, 32'hFFFF_FFFF, 2'd0);
    wait_done(1'b0, 1'b1, "after_abort");
  endtask

  task automatic test_restart_reset();
    bit pulsed = 1'b0;
    bit hit = 1'b0;
    int at20 = -1;
    start_sweep(1'b0, 32'hFFFF_FFFF, 2'd0);
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (stim1 == 5'd3 && !pulsed) begin
        start1 = 1'b1;
        pulsed = 1'b1;
      end
      if (stim1 == 5'd20) begin
        hit = 1'b1;
        at20 = n;
      end
    end
    start1 = 1'b0;
    checks++;
    if (at20 != 60) begin
      errors++; $display("FAIL restart stim20 edge got %0d want 60", at20);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stim1, busy1, done1, tbl1, ones1, match1, mv1, fm1} !== '0) begin
      errors++; $display("FAIL midreset outputs got %h want 0", {stim1, busy1, done1, tbl1, ones1, match1, mv1, fm1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, stim1} !== 7'd0) begin
      errors++; $display("FAIL postreset idle busy/done/stim got %b%b %0d want 00 0", busy1, done1, stim1);
    end
    sbq.push_back('{tbl: 32'hAAAA_AAAA, ones: 6'd16, m: 1'b1, mv: 1'b0, fm: 5'd0, lat: 96});
    start_sweep(1'b0, 32'hAAAA_AAAA, 2'd3);
    wait_done(1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_start_with_abort();
    @(negedge clk);
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || tbl1 !== 32'hAAAA_AAAA || match1 !== 1'b1) begin
      errors++; $display("FAIL start_abort busy/table/match got %b %h %b want 0 aaaaaaaa 1", busy1, tbl1, match1);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_and5();
    test_nor_ab();
    test_abort();
    test_restart_reset();
    test_start_with_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
